// File: rtl/lsu_uop_tracker_pkg.sv
// Shared RVV backend definitions for the LSU uop tracker: default sizing and
// the trap-handling state encoding.
package lsu_uop_tracker_pkg;

    localparam int unsigned DEFAULT_DEPTH  = 8;
    localparam int unsigned DEFAULT_UOP_W  = 128;
    localparam int unsigned DEFAULT_RESP_W = 64;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ACK   = 2'd2
    } trk_state_e;

endpackage

// File: rtl/lsu_tracker_entry_ram.sv
// Tracker entry storage: per-entry busy/done flags and response payload.
// Flush wipes every flag; clear retires one entry; alloc and response update flags.
module lsu_tracker_entry_ram #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned RESP_W = 64,
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              alloc_en_i,
    input  logic [TAG_W-1:0]  alloc_idx_i,
    input  logic              rsp_en_i,
    input  logic [TAG_W-1:0]  rsp_idx_i,
    input  logic [RESP_W-1:0] rsp_data_i,
    input  logic              clr_en_i,
    input  logic [TAG_W-1:0]  clr_idx_i,
    input  logic [TAG_W-1:0]  rd_idx_i,
    output logic [DEPTH-1:0]  busy_o,
    output logic [DEPTH-1:0]  done_o,
    output logic [RESP_W-1:0] rd_data_o
);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [RESP_W-1:0] data_q [DEPTH];

    // Per-entry flag update; the top never targets one entry with two ports at once.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (flush_i) begin
                busy_d[i] = 1'b0;
                done_d[i] = 1'b0;
            end else if (clr_en_i && (clr_idx_i == TAG_W'(i))) begin
                busy_d[i] = 1'b0;
                done_d[i] = 1'b0;
            end else if (alloc_en_i && (alloc_idx_i == TAG_W'(i))) begin
                busy_d[i] = 1'b1;
                done_d[i] = 1'b0;
            end else if (rsp_en_i && (rsp_idx_i == TAG_W'(i))) begin
                busy_d[i] = busy_q[i];
                done_d[i] = 1'b1;
            end else begin
                busy_d[i] = busy_q[i];
                done_d[i] = done_q[i];
            end
        end
    end

    // Flag and payload registers; payload is zeroed on reset so outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            done_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rsp_en_i && !flush_i && (rsp_idx_i == TAG_W'(i))) begin
                    data_q[i] <= rsp_data_i;
                end
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/lsu_uop_tracker.sv
// Tags LSU uops on issue, collects out-of-order LSU feedback and returns it to
// the RVV core in issue order; a trap flushes every outstanding entry.
module lsu_uop_tracker
    import lsu_uop_tracker_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned UOP_W  = DEFAULT_UOP_W,
    parameter int unsigned RESP_W = DEFAULT_RESP_W,
    localparam int unsigned TAG_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uop_valid_in,
    input  logic [UOP_W-1:0]  uop_in,
    output logic              uop_ready_out,
    output logic              lsu_uop_valid,
    output logic [UOP_W-1:0]  lsu_uop,
    output logic [TAG_W-1:0]  lsu_uop_tag,
    input  logic              lsu_uop_ready,
    input  logic              lsu_rsp_valid,
    input  logic [TAG_W-1:0]  lsu_rsp_tag,
    input  logic [RESP_W-1:0] lsu_rsp_data,
    output logic              rvv_rsp_valid,
    output logic [RESP_W-1:0] rvv_rsp_data,
    input  logic              rvv_rsp_ready,
    input  logic              trap_valid_rvs2rvv,
    output logic              trap_ready_rvv2rvs,
    output logic [CNT_W-1:0]  occupancy
);

    trk_state_e        state_q, state_d;
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full_s;
    logic              run_s;
    logic              flush_s;
    logic              issue_ok_s;
    logic              alloc_s;
    logic              rsp_ok_s;
    logic              head_ready_s;
    logic              retire_s;
    logic [DEPTH-1:0]  busy_s;
    logic [DEPTH-1:0]  done_s;
    logic [RESP_W-1:0] head_data_s;

    assign full_s       = (count_q == CNT_W'(DEPTH));
    assign run_s        = (state_q == ST_RUN);
    assign flush_s      = (state_q == ST_FLUSH);
    assign issue_ok_s   = ~full_s & run_s;
    assign alloc_s      = uop_valid_in & lsu_uop_ready & issue_ok_s;
    assign rsp_ok_s     = lsu_rsp_valid & busy_s[lsu_rsp_tag] & ~done_s[lsu_rsp_tag];
    assign head_ready_s = run_s & busy_s[head_q] & done_s[head_q];
    assign retire_s     = head_ready_s & rvv_rsp_ready;

    // Issue side is a pass-through, forced quiet while reset is held.
    assign lsu_uop_valid      = rst_n & uop_valid_in & issue_ok_s;
    assign uop_ready_out      = rst_n & lsu_uop_ready & issue_ok_s;
    assign lsu_uop            = rst_n ? uop_in : '0;
    assign lsu_uop_tag        = tail_q;
    assign rvv_rsp_valid      = head_ready_s;
    assign rvv_rsp_data       = head_data_s;
    assign trap_ready_rvv2rvs = (state_q == ST_ACK);
    assign occupancy          = count_q;

    lsu_tracker_entry_ram #(
        .DEPTH  (DEPTH),
        .RESP_W (RESP_W)
    ) u_entry_ram (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_s),
        .alloc_en_i  (alloc_s),
        .alloc_idx_i (tail_q),
        .rsp_en_i    (rsp_ok_s),
        .rsp_idx_i   (lsu_rsp_tag),
        .rsp_data_i  (lsu_rsp_data),
        .clr_en_i    (retire_s),
        .clr_idx_i   (head_q),
        .rd_idx_i    (head_q),
        .busy_o      (busy_s),
        .done_o      (done_s),
        .rd_data_o   (head_data_s)
    );

    // Next-state for the trap FSM and the circular-buffer pointers.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (state_q)
            ST_RUN: begin
                if (alloc_s) begin
                    tail_d = tail_q + TAG_W'(1);
                end else begin
                    tail_d = tail_q;
                end
                if (retire_s) begin
                    head_d = head_q + TAG_W'(1);
                end else begin
                    head_d = head_q;
                end
                case ({alloc_s, retire_s})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
                if (trap_valid_rvs2rvv) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (trap_valid_rvs2rvv) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_ACK;
                end
            end
            default: begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                state_d = ST_RUN;
            end
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_lsu_uop_tracker.sv
// Self-checking bench for lsu_uop_tracker: directed scenarios plus a randomized
// run compared against an in-order queue model of the tracker.
module tb_lsu_uop_tracker;

    localparam int DEPTH  = 8;
    localparam int UOP_W  = 128;
    localparam int RESP_W = 64;
    localparam int TAG_W  = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              uop_valid_in;
    logic [UOP_W-1:0]  uop_in;
    logic              uop_ready_out;
    logic              lsu_uop_valid;
    logic [UOP_W-1:0]  lsu_uop;
    logic [TAG_W-1:0]  lsu_uop_tag;
    logic              lsu_uop_ready;
    logic              lsu_rsp_valid;
    logic [TAG_W-1:0]  lsu_rsp_tag;
    logic [RESP_W-1:0] lsu_rsp_data;
    logic              rvv_rsp_valid;
    logic [RESP_W-1:0] rvv_rsp_data;
    logic              rvv_rsp_ready;
    logic              trap_valid_rvs2rvv;
    logic              trap_ready_rvv2rvs;
    logic [CNT_W-1:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    // Model: queue of outstanding tags in issue order; 0=RUN 1=FLUSH 2=ACK.
    int                m_q[$];
    bit                m_done [DEPTH];
    logic [RESP_W-1:0] m_data [DEPTH];
    int                m_next;
    int                m_st;

    lsu_uop_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .uop_valid_in(uop_valid_in), .uop_in(uop_in), .uop_ready_out(uop_ready_out),
        .lsu_uop_valid(lsu_uop_valid), .lsu_uop(lsu_uop), .lsu_uop_tag(lsu_uop_tag),
        .lsu_uop_ready(lsu_uop_ready),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_tag(lsu_rsp_tag), .lsu_rsp_data(lsu_rsp_data),
        .rvv_rsp_valid(rvv_rsp_valid), .rvv_rsp_data(rvv_rsp_data), .rvv_rsp_ready(rvv_rsp_ready),
        .trap_valid_rvs2rvv(trap_valid_rvs2rvv), .trap_ready_rvv2rvs(trap_ready_rvv2rvs),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy(int t);
        foreach (m_q[i]) if (m_q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_rvv_valid();
        return (m_st == 0) && (m_q.size() > 0) && m_done[m_q[0]];
    endfunction

    function automatic bit m_full();
        return m_q.size() == DEPTH;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_next = 0;
        for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
    endtask

    task automatic idle_inputs();
        uop_valid_in = 1'b0; uop_in = '0; lsu_uop_ready = 1'b0;
        lsu_rsp_valid = 1'b0; lsu_rsp_tag = '0; lsu_rsp_data = '0;
        rvv_rsp_ready = 1'b0; trap_valid_rvs2rvv = 1'b0;
    endtask

    // Apply the current inputs to the model as the coming clock edge would, then advance.
    task automatic tick();
        bit alloc, ret, rsp_ok;
        int t;
        alloc  = (m_st == 0) && uop_valid_in && lsu_uop_ready && !m_full();
        ret    = m_rvv_valid() && rvv_rsp_ready;
        t      = int'(lsu_rsp_tag);
        rsp_ok = lsu_rsp_valid && m_busy(t) && !m_done[t];
        if (m_st == 1) begin
            model_clear();
            m_st = 2;
        end else begin
            if (rsp_ok) begin m_done[t] = 1'b1; m_data[t] = lsu_rsp_data; end
            if (ret) begin m_done[m_q[0]] = 1'b0; void'(m_q.pop_front()); end
            if (alloc) begin m_q.push_back(m_next); m_done[m_next] = 1'b0; m_next = (m_next + 1) % DEPTH; end
            if (trap_valid_rvs2rvv) m_st = (m_st == 0) ? 1 : 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        m_st = 0;
        @(posedge clk); @(posedge clk); #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_rsp(int tag, logic [RESP_W-1:0] d);
        lsu_rsp_valid = 1'b1; lsu_rsp_tag = TAG_W'(tag); lsu_rsp_data = d;
        tick();
        lsu_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        m_st = 0;
        uop_valid_in = 1'b1; lsu_uop_ready = 1'b1; rvv_rsp_ready = 1'b1;
        uop_in = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
        @(posedge clk); #1;
        n_cmp++; if (lsu_uop_valid !== 1'b0) begin n_err++; $display("FAIL rst_lsu_valid: got %0b exp 0", lsu_uop_valid); end
        n_cmp++; if (uop_ready_out !== 1'b0) begin n_err++; $display("FAIL rst_uop_ready: got %0b exp 0", uop_ready_out); end
        n_cmp++; if (rvv_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rvv_valid: got %0b exp 0", rvv_rsp_valid); end
        n_cmp++; if (trap_ready_rvv2rvs !== 1'b0) begin n_err++; $display("FAIL rst_trap_ready: got %0b exp 0", trap_ready_rvv2rvs); end
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL rst_occ: got %0d exp 0", occupancy); end
        n_cmp++; if (lsu_uop !== 128'd0) begin n_err++; $display("FAIL rst_lsu_uop: got %0h exp 0", lsu_uop); end
        n_cmp++; if (lsu_uop_tag !== 3'd0) begin n_err++; $display("FAIL rst_tag: got %0d exp 0", lsu_uop_tag); end
        n_cmp++; if (rvv_rsp_data !== 64'd0) begin n_err++; $display("FAIL rst_rvv_data: got %0h exp 0", rvv_rsp_data); end
        do_reset();
    endtask

    task automatic test_order();
        logic [RESP_W-1:0] d [3];
        for (int i = 0; i < 3; i++) begin
            d[i] = {$urandom, $urandom};
            uop_valid_in = 1'b1; lsu_uop_ready = 1'b1; uop_in = {$urandom, $urandom, $urandom, $urandom};
            #1;
            n_cmp++; if (lsu_uop_tag !== TAG_W'(i)) begin n_err++; $display("FAIL order_tag: got %0d exp %0d", lsu_uop_tag, i); end
            n_cmp++; if (lsu_uop_valid !== 1'b1) begin n_err++; $display("FAIL order_issue_valid: got %0b exp 1", lsu_uop_valid); end
            n_cmp++; if (lsu_uop !== uop_in) begin n_err++; $display("FAIL order_passthru: got %0h exp %0h", lsu_uop, uop_in); end
            tick();
        end
        idle_inputs();
        send_rsp(2, d[2]);
        n_cmp++; if (rvv_rsp_valid !== 1'b0) begin n_err++; $display("FAIL order_c_early: got %0b exp 0", rvv_rsp_valid); end
        lsu_rsp_valid = 1'b1; lsu_rsp_tag = 3'd0; lsu_rsp_data = d[0];
        #1;
        n_cmp++; if (rvv_rsp_valid !== 1'b0) begin n_err++; $display("FAIL order_a_same_cycle: got %0b exp 0", rvv_rsp_valid); end
        tick();
        lsu_rsp_valid = 1'b0;
        n_cmp++; if (rvv_rsp_valid !== 1'b1) begin n_err++; $display("FAIL order_a_valid: got %0b exp 1", rvv_rsp_valid); end
        n_cmp++; if (rvv_rsp_data !== d[0]) begin n_err++; $display("FAIL order_a_data: got %0h exp %0h", rvv_rsp_data, d[0]); end
        rvv_rsp_ready = 1'b1;
        tick();
        rvv_rsp_ready = 1'b0;
        n_cmp++; if (rvv_rsp_valid !== 1'b0) begin n_err++; $display("FAIL order_b_wait: got %0b exp 0", rvv_rsp_valid); end
        send_rsp(1, d[1]);
        n_cmp++; if (rvv_rsp_data !== d[1] || rvv_rsp_valid !== 1'b1) begin n_err++; $display("FAIL order_b: got %0b/%0h exp 1/%0h", rvv_rsp_valid, rvv_rsp_data, d[1]); end
        rvv_rsp_ready = 1'b1;
        tick();
        n_cmp++; if (rvv_rsp_data !== d[2] || rvv_rsp_valid !== 1'b1) begin n_err++; $display("FAIL order_c: got %0b/%0h exp 1/%0h", rvv_rsp_valid, rvv_rsp_data, d[2]); end
        tick();
        rvv_rsp_ready = 1'b0;
        n_cmp++; if (rvv_rsp_valid !== 1'b0 || occupancy !== 4'd0) begin n_err++; $display("FAIL order_drained: got %0b/%0d exp 0/0", rvv_rsp_valid, occupancy); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        uop_valid_in = 1'b1; lsu_uop_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            uop_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        n_cmp++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL full_occ: got %0d exp 8", occupancy); end
        n_cmp++; if (uop_ready_out !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0b exp 0", uop_ready_out); end
        n_cmp++; if (lsu_uop_valid !== 1'b0) begin n_err++; $display("FAIL full_valid: got %0b exp 0", lsu_uop_valid); end
        send_rsp(0, 64'h1234_5678_9abc_def0);
        rvv_rsp_ready = 1'b1;
        #1;
        n_cmp++; if (rvv_rsp_valid !== 1'b1 || uop_ready_out !== 1'b0) begin n_err++; $display("FAIL full_retire_cycle: got %0b/%0b exp 1/0", rvv_rsp_valid, uop_ready_out); end
        tick();
        rvv_rsp_ready = 1'b0;
        n_cmp++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL wrap_occ7: got %0d exp 7", occupancy); end
        n_cmp++; if (uop_ready_out !== 1'b1) begin n_err++; $display("FAIL wrap_ready: got %0b exp 1", uop_ready_out); end
        n_cmp++; if (lsu_uop_tag !== 3'd0) begin n_err++; $display("FAIL wrap_tag: got %0d exp 0", lsu_uop_tag); end
        tick();
        n_cmp++; if (occupancy !== 4'd8 || uop_ready_out !== 1'b0) begin n_err++; $display("FAIL wrap_refill: got %0d/%0b exp 8/0", occupancy, uop_ready_out); end
        idle_inputs();
    endtask

    task automatic test_drop();
        logic [RESP_W-1:0] d;
        do_reset();
        d = {$urandom, $urandom};
        uop_valid_in = 1'b1; lsu_uop_ready = 1'b1; uop_in = '1;
        tick();
        idle_inputs();
        send_rsp(0, d);
        n_cmp++; if (rvv_rsp_valid !== 1'b1 || rvv_rsp_data !== d) begin n_err++; $display("FAIL drop_base: got %0b/%0h exp 1/%0h", rvv_rsp_valid, rvv_rsp_data, d); end
        send_rsp(5, ~d);
        n_cmp++; if (occupancy !== 4'd1 || rvv_rsp_data !== d) begin n_err++; $display("FAIL drop_idle_tag: got %0d/%0h exp 1/%0h", occupancy, rvv_rsp_data, d); end
        send_rsp(0, d ^ 64'h5555_5555_5555_5555);
        n_cmp++; if (occupancy !== 4'd1 || rvv_rsp_data !== d) begin n_err++; $display("FAIL drop_dup: got %0d/%0h exp 1/%0h", occupancy, rvv_rsp_data, d); end
        rvv_rsp_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_trap();
        do_reset();
        uop_valid_in = 1'b1; lsu_uop_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin uop_in = {$urandom, $urandom, $urandom, $urandom}; tick(); end
        uop_valid_in = 1'b0;
        trap_valid_rvs2rvv = 1'b1;
        tick();
        uop_valid_in = 1'b1;
        lsu_rsp_valid = 1'b1; lsu_rsp_tag = 3'd0; lsu_rsp_data = {$urandom, $urandom};
        #1;
        n_cmp++; if (trap_ready_rvv2rvs !== 1'b0 || lsu_uop_valid !== 1'b0 || uop_ready_out !== 1'b0) begin n_err++; $display("FAIL trap_flush_cycle: got %0b/%0b/%0b exp 0/0/0", trap_ready_rvv2rvs, lsu_uop_valid, uop_ready_out); end
        tick();
        lsu_rsp_tag = 3'd1;
        n_cmp++; if (trap_ready_rvv2rvs !== 1'b1) begin n_err++; $display("FAIL trap_ack: got %0b exp 1", trap_ready_rvv2rvs); end
        n_cmp++; if (occupancy !== 4'd0 || lsu_uop_valid !== 1'b0) begin n_err++; $display("FAIL trap_ack_state: got %0d/%0b exp 0/0", occupancy, lsu_uop_valid); end
        tick();
        trap_valid_rvs2rvv = 1'b0; uop_valid_in = 1'b0; lsu_rsp_tag = 3'd2;
        tick();
        lsu_rsp_valid = 1'b0;
        n_cmp++; if (trap_ready_rvv2rvs !== 1'b0 || rvv_rsp_valid !== 1'b0 || occupancy !== 4'd0) begin n_err++; $display("FAIL trap_after: got %0b/%0b/%0d exp 0/0/0", trap_ready_rvv2rvs, rvv_rsp_valid, occupancy); end
        n_cmp++; if (lsu_uop_tag !== 3'd0) begin n_err++; $display("FAIL trap_tag: got %0d exp 0", lsu_uop_tag); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        uop_valid_in = 1'b1; lsu_uop_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin uop_in = {$urandom, $urandom, $urandom, $urandom}; tick(); end
        idle_inputs();
        send_rsp(0, {$urandom, $urandom});
        send_rsp(1, {$urandom, $urandom});
        uop_valid_in = 1'b1; lsu_uop_ready = 1'b1; rvv_rsp_ready = 1'b1; uop_in = '1;
        rst_n = 1'b0;
        model_clear();
        m_st = 0;
        #1;
        n_cmp++; if (lsu_uop_valid !== 1'b0 || uop_ready_out !== 1'b0 || rvv_rsp_valid !== 1'b0 || trap_ready_rvv2rvs !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctl: got %0b%0b%0b%0b exp 0000", lsu_uop_valid, uop_ready_out, rvv_rsp_valid, trap_ready_rvv2rvs); end
        n_cmp++; if (occupancy !== 4'd0 || lsu_uop !== 128'd0 || rvv_rsp_data !== 64'd0 || lsu_uop_tag !== 3'd0) begin n_err++; $display("FAIL mid_rst_data: got %0d/%0h/%0h/%0d exp 0/0/0/0", occupancy, lsu_uop, rvv_rsp_data, lsu_uop_tag); end
        idle_inputs();
        @(posedge clk); @(posedge clk); #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rvv_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lsu_rsp_valid = 1'b1; lsu_rsp_tag = TAG_W'(i); lsu_rsp_data = {$urandom, $urandom};
            tick();
            n_cmp++; if (rvv_rsp_valid !== 1'b0 || occupancy !== 4'd0) begin n_err++; $display("FAIL mid_rst_after: got %0b/%0d exp 0/0", rvv_rsp_valid, occupancy); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        bit exp_v;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            uop_valid_in = ($urandom_range(0, 3) != 0);
            uop_in = {$urandom, $urandom, $urandom, $urandom};
            lsu_uop_ready = ($urandom_range(0, 3) != 0);
            rvv_rsp_ready = ($urandom_range(0, 2) != 0);
            lsu_rsp_valid = ($urandom_range(0, 1) != 0);
            lsu_rsp_data = {$urandom, $urandom};
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                lsu_rsp_tag = TAG_W'(m_q[$urandom_range(0, m_q.size() - 1)]);
            else
                lsu_rsp_tag = TAG_W'($urandom_range(0, DEPTH - 1));
            trap_valid_rvs2rvv = ($urandom_range(0, 59) == 0);
            #1;
            exp_v = m_rvv_valid();
            n_cmp++; if (lsu_uop_valid !== (uop_valid_in && !m_full() && m_st == 0)) begin n_err++; $display("FAIL rnd_lsu_valid c%0d: got %0b", cyc, lsu_uop_valid); end
            n_cmp++; if (uop_ready_out !== (lsu_uop_ready && !m_full() && m_st == 0)) begin n_err++; $display("FAIL rnd_uop_ready c%0d: got %0b", cyc, uop_ready_out); end
            n_cmp++; if (lsu_uop_tag !== TAG_W'(m_next)) begin n_err++; $display("FAIL rnd_tag c%0d: got %0d exp %0d", cyc, lsu_uop_tag, m_next); end
            n_cmp++; if (lsu_uop !== uop_in) begin n_err++; $display("FAIL rnd_passthru c%0d: got %0h exp %0h", cyc, lsu_uop, uop_in); end
            n_cmp++; if (rvv_rsp_valid !== exp_v) begin n_err++; $display("FAIL rnd_rvv_valid c%0d: got %0b exp %0b", cyc, rvv_rsp_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (rvv_rsp_data !== m_data[m_q[0]]) begin n_err++; $display("FAIL rnd_rvv_data c%0d: got %0h exp %0h", cyc, rvv_rsp_data, m_data[m_q[0]]); end
            end
            n_cmp++; if (trap_ready_rvv2rvs !== (m_st == 2)) begin n_err++; $display("FAIL rnd_trap_ready c%0d: got %0b exp %0b", cyc, trap_ready_rvv2rvs, (m_st == 2)); end
            n_cmp++; if (occupancy !== CNT_W'(m_q.size())) begin n_err++; $display("FAIL rnd_occ c%0d: got %0d exp %0d", cyc, occupancy, m_q.size()); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_order();
        test_full_wrap();
        test_drop();
        test_trap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_uop_tracker.md
LSU_UOP_TRACKER -- requirements
Module: lsu_uop_tracker

Interface
REQ-001 Parameter DEPTH, default 8: tracker entries, power of two, at least 2.
REQ-002 Parameter UOP_W, default 128: LSU uop payload width.
REQ-003 Parameter RESP_W, default 64: LSU feedback payload width.
REQ-004 Derived TAG_W = log2(DEPTH); CNT_W = log2(DEPTH)+1.
REQ-005 clk  in  1  single clock; all state rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 uop_valid_in  in  1  RVV offers LSU uop.
REQ-008 uop_in  in  UOP_W  uop payload.
REQ-009 uop_ready_out  out  1  tracker accepts uop.
REQ-010 lsu_uop_valid  out  1  uop to LSU.
REQ-011 lsu_uop  out  UOP_W  uop_in passed through.
REQ-012 lsu_uop_tag  out  TAG_W  allocated entry index.
REQ-013 lsu_uop_ready  in  1  LSU accepts uop.
REQ-014 lsu_rsp_valid  in  1  LSU feedback valid, any order.
REQ-015 lsu_rsp_tag  in  TAG_W  tag of completing uop.
REQ-016 lsu_rsp_data  in  RESP_W  feedback payload.
REQ-017 rvv_rsp_valid  out  1  in-order feedback to RVV.
REQ-018 rvv_rsp_data  out  RESP_W  feedback payload.
REQ-019 rvv_rsp_ready  in  1  RVV accepts feedback.
REQ-020 trap_valid_rvs2rvv  in  1  trap request.
REQ-021 trap_ready_rvv2rvs  out  1  trap acknowledge.
REQ-022 occupancy  out  CNT_W  busy entries, 0..DEPTH.

Function
REQ-023 Entries form a circular buffer with head, tail and count; each entry holds busy, done, data.
REQ-024 full = (count==DEPTH); empty = (count==0).
REQ-025 Issue is combinational pass-through: lsu_uop_valid = uop_valid_in & !full & state==RUN; uop_ready_out = lsu_uop_ready & !full & state==RUN; lsu_uop_tag = tail.
REQ-026 On the issue handshake, entry[tail] gets busy=1 and done=0, and tail increments modulo DEPTH.
REQ-027 A response with entry[tag] busy and not done stores data and sets done; any other response is dropped silently.
REQ-028 rvv_rsp_valid = entry[head].busy & entry[head].done, driven from registers only; minimum response-to-RVV latency is 1 cycle.
REQ-029 On the rvv_rsp handshake, entry[head] is cleared and head increments modulo DEPTH.
REQ-030 Allocate and retire in the same cycle leave count unchanged; full is evaluated on pre-edge count, with no same-cycle bypass.
REQ-031 A response and a retire in the same cycle on different entries both take effect.
REQ-032 FSM states: RUN, FLUSH, ACK.
- RUN -> FLUSH when trap_valid_rvs2rvv=1.
- FLUSH: all busy/done cleared; head=tail=count=0; retire suppressed; next state ACK.
- ACK: trap_ready_rvv2rvs=1; return to RUN on the trap handshake.
REQ-033 Issue and retire are blocked in FLUSH and ACK; responses for flushed tags are dropped per REQ-027.

Reset
REQ-034 Asynchronous reset (rst_n=0) puts state=RUN, head=tail=count=0 and all busy/done=0.
REQ-035 During reset, all valid/ready outputs are 0, occupancy=0, and data outputs are 0.
REQ-036 Reset mid-operation discards all entries; no response is emitted after reset release until a new uop is issued.

Structure
REQ-037 The FSM state enum and the default DEPTH/UOP_W/RESP_W constants live in the shared rvv backend package.
REQ-038 One sub-module, lsu_tracker_entry_ram (DEPTH x {busy, done, data}, one write port for allocate/response, one clear port), is natural; the control logic remains in the top.

Verification
REQ-039 Issue uops A,B,C (tags 0,1,2); respond in order C,A,B -> RVV sees A, B, C in order; A appears 1 cycle after its response.
REQ-040 DEPTH=8: issue 8 uops with no responses -> occupancy=8, uop_ready_out=0; retire one -> ready returns the next cycle, and the new tag is 0 (wrap-around).
REQ-041 Full, with a head retire and an offered uop in the same cycle -> no allocation that cycle; allocation occurs the next cycle.
REQ-042 Response on an idle tag 5, then a duplicate response on tag 0 -> both dropped; occupancy and output data unchanged.
REQ-043 3 busy entries, assert trap_valid_rvs2rvv -> FLUSH one cycle, then trap_ready_rvv2rvs=1; occupancy=0; late responses on tags 0-2 are ignored.
REQ-044 Assert rst_n=0 with 4 busy entries mid-stream -> all outputs 0 immediately; after release, no rvv_rsp_valid without new issue.
